// File: rtl/rhd_sched_pkg.sv
// Shared constants and state encoding for the RHD2000 frame scheduler.
package rhd_sched_pkg;
   localparam int NUM_SLOTS      = 35;
   localparam int AUX_FIRST_SLOT = 32;
   localparam int NUM_AUX        = 3;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   function automatic logic is_aux_slot(input logic [5:0] ch);
      return ch >= 6'(AUX_FIRST_SLOT);
   endfunction
endpackage

// File: rtl/aux_index_counter.sv
// One auxiliary command-list pointer with shadowed end/loop bounds.
module aux_index_counter #(
   parameter int ADDR_W = 10
) (
   input  logic              dataclk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] end_in,
   input  logic [ADDR_W-1:0] loop_in,
   output logic [ADDR_W-1:0] addr
);
   logic [ADDR_W-1:0] end_sh, loop_sh;

   // step uses the bounds captured at the previous sample boundary
   always_ff @(posedge dataclk or negedge rst_n) begin
      if (!rst_n) begin
         end_sh  <= '0;
         loop_sh <= '0;
         addr    <= '0;
      end else begin
         if (load) begin
            end_sh  <= end_in;
            loop_sh <= loop_in;
         end
         if (clear)     addr <= '0;
         else if (step) addr <= (addr >= end_sh) ? loop_sh : addr + 1'b1;
      end
   end
endmodule

// File: rtl/rhd_frame_scheduler.sv
// Per-sample SPI frame sequencer: slot index, aux list pointers, settle latch, sample count.
module rhd_frame_scheduler
   import rhd_sched_pkg::*;
#(
   parameter int FRAME_CYCLES = 80,
   parameter int ADDR_W       = 10
) (
   input  logic                    dataclk,
   input  logic                    rst_n,
   input  logic                    run,
   input  logic [31:0]             num_samples,
   input  logic                    dsp_settle_in,
   input  logic [3*ADDR_W-1:0]     aux_end,
   input  logic [3*ADDR_W-1:0]     aux_loop,
   output logic [5:0]              channel,
   output logic                    frame_start,
   output logic                    sample_start,
   output logic [3*ADDR_W-1:0]     aux_addr,
   output logic                    dsp_settle,
   output logic [31:0]             timestep,
   output logic                    running,
   output logic                    done
);
   state_t     state;
   logic [7:0] counter;
   logic       frame_end, last_slot, wrap, finish;
   logic       aux_clear, aux_load;
   logic [NUM_AUX-1:0][ADDR_W-1:0] aux_addr_v;

   assign frame_end = (counter == 8'(FRAME_CYCLES-1));
   assign last_slot = (channel == 6'(NUM_SLOTS-1));
   assign wrap      = (state == ST_RUN) && frame_end && last_slot;
   assign finish    = (num_samples != 32'd0) && ((timestep + 32'd1) == num_samples);
   assign aux_clear = (state == ST_IDLE) && run;
   assign aux_load  = aux_clear || wrap;
   assign aux_addr  = aux_addr_v;

   for (genvar i = 0; i < NUM_AUX; i++) begin : g_aux
      aux_index_counter #(.ADDR_W(ADDR_W)) u_aux (
         .dataclk (dataclk),
         .rst_n   (rst_n),
         .clear   (aux_clear),
         .load    (aux_load),
         .step    (wrap),
         .end_in  (aux_end[i*ADDR_W +: ADDR_W]),
         .loop_in (aux_loop[i*ADDR_W +: ADDR_W]),
         .addr    (aux_addr_v[i])
      );
   end

   // Strobes are registered one cycle early so they line up with counter==0.
   always_ff @(posedge dataclk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         counter      <= '0;
         channel      <= '0;
         frame_start  <= 1'b0;
         sample_start <= 1'b0;
         dsp_settle   <= 1'b0;
         timestep     <= '0;
         running      <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               channel      <= '0;
               frame_start  <= 1'b0;
               sample_start <= 1'b0;
               running      <= 1'b0;
               if (run) begin
                  state        <= ST_RUN;
                  counter      <= '0;
                  timestep     <= '0;
                  dsp_settle   <= dsp_settle_in;
                  frame_start  <= 1'b1;
                  sample_start <= 1'b1;
                  running      <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!frame_end) begin
                  counter      <= counter + 8'd1;
                  frame_start  <= 1'b0;
                  sample_start <= 1'b0;
               end else if (!last_slot) begin
                  counter      <= '0;
                  channel      <= channel + 6'd1;
                  frame_start  <= 1'b1;
                  sample_start <= 1'b0;
               end else begin
                  counter    <= '0;
                  channel    <= '0;
                  timestep   <= timestep + 32'd1;
                  dsp_settle <= dsp_settle_in;
                  if (finish || !run) begin
                     state        <= ST_IDLE;
                     done         <= finish;
                     running      <= 1'b0;
                     frame_start  <= 1'b0;
                     sample_start <= 1'b0;
                  end else begin
                     frame_start  <= 1'b1;
                     sample_start <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rhd_frame_scheduler.sv
// Directed bench for rhd_frame_scheduler with FRAME_CYCLES=80.
module tb_rhd_frame_scheduler;
   localparam int AW = 10;

   logic          dataclk = 1'b0;
   logic          rst_n;
   logic          run;
   logic [31:0]   num_samples;
   logic          dsp_settle_in;
   logic [3*AW-1:0] aux_end, aux_loop;
   logic [5:0]    channel;
   logic          frame_start, sample_start, dsp_settle, running, done;
   logic [3*AW-1:0] aux_addr;
   logic [31:0]   timestep;

   int checks = 0;
   int errors = 0;

   rhd_frame_scheduler #(.FRAME_CYCLES(80), .ADDR_W(AW)) dut (
      .dataclk       (dataclk),
      .rst_n         (rst_n),
      .run           (run),
      .num_samples   (num_samples),
      .dsp_settle_in (dsp_settle_in),
      .aux_end       (aux_end),
      .aux_loop      (aux_loop),
      .channel       (channel),
      .frame_start   (frame_start),
      .sample_start  (sample_start),
      .aux_addr      (aux_addr),
      .dsp_settle    (dsp_settle),
      .timestep      (timestep),
      .running       (running),
      .done          (done)
   );

   always #5 dataclk = ~dataclk;

   task automatic tick();
      @(posedge dataclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int cnt;
      int bad;
      logic [AW-1:0] exp_a [5];
      bit seen;
      exp_a[0] = 10'd1; exp_a[1] = 10'd2; exp_a[2] = 10'd1; exp_a[3] = 10'd2; exp_a[4] = 10'd1;

      rst_n = 1'b0; run = 1'b0; num_samples = 0; dsp_settle_in = 1'b0;
      aux_end  = {10'd5, 10'd5, 10'd5};
      aux_loop = '0;
      repeat (3) tick();
      check("rst_channel", 32'(channel), 0);
      check("rst_strobes", {30'd0, frame_start, sample_start}, 0);
      check("rst_aux", 32'(aux_addr), 0);
      check("rst_misc", {29'd0, dsp_settle, running, done}, 0);
      check("rst_timestep", timestep, 0);
      rst_n = 1'b1;
      tick();

      // unlimited run: slot walk and strobe spacing
      run = 1'b1;
      tick();
      check("start_strobes", {30'd0, frame_start, sample_start}, 32'd3);
      check("start_running", {31'd0, running}, 1);
      cnt = 0;
      repeat (79) begin tick(); if (frame_start) cnt++; end
      check("fs_gap", cnt, 0);
      tick();
      check("frame1", {24'd0, channel, frame_start, sample_start}, {24'd0, 6'd1, 1'b1, 1'b0});
      bad = 0;
      for (int ch = 2; ch < 35; ch++) begin
         repeat (80) tick();
         if (channel != 6'(ch) || !frame_start || sample_start) bad++;
      end
      check("slot_walk", bad, 0);
      repeat (80) tick();
      check("sample2", {24'd0, channel, frame_start, sample_start}, {24'd0, 6'd0, 1'b1, 1'b1});
      check("ts1", timestep, 1);
      check("aux_step1", 32'(aux_addr), 32'({10'd1, 10'd1, 10'd1}));

      // async reset mid-frame at channel 17
      repeat (17*80 + 30) tick();
      check("pre_rst_ch", 32'(channel), 17);
      run = 1'b0;
      rst_n = 1'b0;
      #1;
      check("arst_channel", 32'(channel), 0);
      check("arst_flags", {27'd0, frame_start, sample_start, dsp_settle, running, done}, 0);
      check("arst_aux", 32'(aux_addr), 0);
      check("arst_ts", timestep, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // finite run of 3 samples
      num_samples = 3;
      run = 1'b1;
      tick();
      cnt = 0; seen = 1'b0;
      for (int k = 0; k < 9000 && !seen; k++) begin
         tick();
         cnt++;
         if (done) begin seen = 1'b1; run = 1'b0; end
      end
      check("done_latency", cnt, 8400);
      check("done_ts", timestep, 3);
      check("done_running", {31'd0, running}, 0);
      check("done_aux", 32'(aux_addr), 32'({10'd3, 10'd3, 10'd3}));
      tick();
      check("done_pulse", {30'd0, done, running}, 0);
      check("idle_hold_ts", timestep, 3);

      // aux list wrap, end_a=2 loop_a=1; done on the 6th wrap with run already low
      aux_end  = {10'd5, 10'd5, 10'd2};
      aux_loop = {10'd0, 10'd0, 10'd1};
      num_samples = 6;
      run = 1'b1;
      tick();
      check("auxw_0", 32'(aux_addr[AW-1:0]), 0);
      bad = 0;
      for (int s = 0; s < 5; s++) begin
         repeat (2800) tick();
         if (aux_addr[AW-1:0] !== exp_a[s] || !sample_start) bad++;
      end
      check("auxw_seq", bad, 0);
      run = 1'b0;
      repeat (2800) tick();
      check("auxw_done", {31'd0, done}, 1);
      check("auxw_ts", timestep, 6);
      check("auxw_final", 32'(aux_addr), 32'({10'd0, 10'd0, 10'd2}));
      tick();

      // mid-sample config change is deferred to the next sample boundary
      aux_end  = {10'd5, 10'd5, 10'd5};
      aux_loop = '0;
      num_samples = 0;
      dsp_settle_in = 1'b0;
      run = 1'b1;
      tick();
      check("cfg_settle0", {31'd0, dsp_settle}, 0);
      repeat (805) tick();
      check("cfg_ch10", 32'(channel), 10);
      aux_end = {10'd5, 10'd0, 10'd5};
      dsp_settle_in = 1'b1;
      repeat (1994) tick();
      check("cfg_hold", {24'd0, channel, 1'b0, dsp_settle}, {24'd0, 6'd34, 1'b0, 1'b0});
      tick();
      check("cfg_wrap", {20'd0, aux_addr[2*AW-1:AW], sample_start, dsp_settle}, {20'd0, 10'd1, 1'b1, 1'b1});
      repeat (2800) tick();
      check("cfg_newend", 32'(aux_addr[2*AW-1:AW]), 0);
      check("cfg_ts", timestep, 2);

      // clean stop requested at channel 5
      repeat (400) tick();
      check("stop_ch5", 32'(channel), 5);
      run = 1'b0;
      repeat (2399) tick();
      check("stop_ch34", {24'd0, channel, running, done}, {24'd0, 6'd34, 1'b1, 1'b0});
      tick();
      check("stop_idle", {24'd0, channel, running, done}, 0);
      check("stop_ts", timestep, 3);
      tick();
      check("stop_stay", {30'd0, running, frame_start}, 0);
      run = 1'b1;
      tick();
      check("restart_ts", timestep, 0);
      check("restart_aux", 32'(aux_addr), 0);
      check("restart_run", {30'd0, running, sample_start}, 32'd3);
      run = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
